// File: rtl/uart_tx_fifo_pkg.sv
// Shared types for the buffered UART transmitter: parity modes and serializer states.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // The reserved encoding 3 is sent as a frame without parity.
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return PARITY_EVEN;
      2'd2:    return PARITY_ODD;
      default: return PARITY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side valid/ready word handshake into the UART transmit buffer.
interface uart_tx_fifo_if #(
  parameter int DataBits = 8
) ();
  logic                valid;
  logic                ready;
  logic [DataBits-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with fall-through read port: the head word is visible while not empty.
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wr_data,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = (AddrW + 1)'(1);

  logic [Width-1:0] mem [Depth];
  logic [AddrW:0]   wr_ptr_reg;
  logic [AddrW:0]   rd_ptr_reg;

  // Extra pointer MSB tells a full buffer from an empty one when the addresses match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AddrW] != rd_ptr_reg[AddrW]) &&
                   (wr_ptr_reg[AddrW-1:0] == rd_ptr_reg[AddrW-1:0]);
  assign rd_data = mem[rd_ptr_reg[AddrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push && !full) begin
      mem[wr_ptr_reg[AddrW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr_reg <= wr_ptr_reg + PtrOne;
      end
      if (pop && !empty) begin
        rd_ptr_reg <= rd_ptr_reg + PtrOne;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words queue in a FIFO and leave LSB-first on tx_o,
// with bit period, parity and stop count captured per frame when the word is popped.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DataBits  = 8,
  parameter int FifoDepth = 4,
  parameter int DivWidth  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  uart_tx_fifo_if.slave       in_if,
  input  logic [1:0]          parity_i,
  input  logic                two_stop_i,
  input  logic [DivWidth-1:0] divisor_i,
  output logic                tx_o,
  output logic                busy_o
);
  localparam int IdxW = (DataBits > 1) ? $clog2(DataBits) : 1;
  localparam logic [IdxW-1:0]     LastIdx = IdxW'(DataBits - 1);
  localparam logic [IdxW-1:0]     IdxOne  = IdxW'(1);
  localparam logic [DivWidth-1:0] DivOne  = DivWidth'(1);

  tx_state_e           state_reg;
  logic [DivWidth-1:0] cnt_reg;
  logic [DivWidth-1:0] div_reg;
  logic [IdxW-1:0]     bit_idx_reg;
  logic [DataBits-1:0] shift_reg;
  parity_e             par_mode_reg;
  logic                two_stop_reg;
  logic                stop_second_reg;
  logic                parity_acc_reg;
  logic                tx_reg;
  logic                busy_reg;

  logic                fifo_full;
  logic                fifo_empty;
  logic [DataBits-1:0] fifo_data;
  logic                push;
  logic                pop;
  logic                bit_done;
  logic                frame_end;
  logic [DivWidth-1:0] eff_div;

  assign in_if.ready = !fifo_full && !rst_i;
  assign push        = in_if.valid && in_if.ready;
  assign eff_div     = (divisor_i == '0) ? DivOne : divisor_i;
  assign bit_done    = (cnt_reg == '0);
  assign frame_end   = (state_reg == STOP) && bit_done && (!two_stop_reg || stop_second_reg);
  // Popping at the last STOP edge chains the next start bit with no idle gap.
  assign pop         = !fifo_empty && ((state_reg == IDLE) || frame_end);

  assign tx_o   = tx_reg;
  assign busy_o = busy_reg;

  sync_fifo #(
    .Width (DataBits),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push),
    .pop     (pop),
    .wr_data (in_if.data),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      div_reg         <= DivOne;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      par_mode_reg    <= PARITY_NONE;
      two_stop_reg    <= 1'b0;
      stop_second_reg <= 1'b0;
      parity_acc_reg  <= 1'b0;
      tx_reg          <= 1'b1;
      busy_reg        <= 1'b0;
    end else if (pop) begin
      state_reg       <= START;
      shift_reg       <= fifo_data;
      par_mode_reg    <= decode_parity(parity_i);
      two_stop_reg    <= two_stop_i;
      div_reg         <= eff_div;
      cnt_reg         <= eff_div - DivOne;
      parity_acc_reg  <= 1'b0;
      stop_second_reg <= 1'b0;
      tx_reg          <= 1'b0;
      busy_reg        <= 1'b1;
    end else if (!bit_done) begin
      cnt_reg <= cnt_reg - DivOne;
    end else begin
      case (state_reg)
        START: begin
          state_reg      <= DATA;
          bit_idx_reg    <= '0;
          tx_reg         <= shift_reg[0];
          parity_acc_reg <= parity_acc_reg ^ shift_reg[0];
          shift_reg      <= shift_reg >> 1;
          cnt_reg        <= div_reg - DivOne;
        end
        DATA: begin
          cnt_reg <= div_reg - DivOne;
          if (bit_idx_reg == LastIdx) begin
            if (par_mode_reg == PARITY_NONE) begin
              state_reg <= STOP;
              tx_reg    <= 1'b1;
            end else begin
              state_reg <= PARITY;
              tx_reg    <= parity_acc_reg ^ (par_mode_reg == PARITY_ODD);
            end
          end else begin
            bit_idx_reg    <= bit_idx_reg + IdxOne;
            tx_reg         <= shift_reg[0];
            parity_acc_reg <= parity_acc_reg ^ shift_reg[0];
            shift_reg      <= shift_reg >> 1;
          end
        end
        PARITY: begin
          state_reg <= STOP;
          tx_reg    <= 1'b1;
          cnt_reg   <= div_reg - DivOne;
        end
        STOP: begin
          if (two_stop_reg && !stop_second_reg) begin
            stop_second_reg <= 1'b1;
            cnt_reg         <= div_reg - DivOne;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter: the next generation of the single-word 8N1 transmitter. It accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first on `tx_o`. Data width, FIFO depth and divisor width are set at elaboration. Bit period, parity and stop-bit count are set at run time. It sits between a bus-side producer (CPU register block or DMA) and the board TX pin.

## Interface
Parameters:
- `DataBits`, 8: data bits per frame, legal 5..9.
- `FifoDepth`, 4: word buffer depth, power of two, ≥ 2.
- `DivWidth`, 16: width of `divisor_i`.

Ports:
- `clk_i`  in  1  sole clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  producer has a word.
- `ready_o`  out  1  FIFO can accept; transfer = `valid_i && ready_o` at a rising edge.
- `data_i`  in  DataBits  word to send.
- `parity_i`  in  2  0 = none, 1 = even, 2 = odd, 3 = reserved (treated as none).
- `two_stop_i`  in  1  0 = one stop bit, 1 = two stop bits.
- `divisor_i`  in  DivWidth  clock cycles per bit; 0 is treated as 1.
- `tx_o`  out  1  serial line, idle high.
- `busy_o`  out  1  FIFO non-empty or a frame in flight.

## Operation
- **Reset values:**
  - `tx_o` = 1, `busy_o` = 0, FIFO empty, serializer in IDLE.
  - `ready_o` is forced to 0 while `rst_i` is high, and returns to 1 the first cycle after.
  - A transfer presented during reset is dropped.
- **Reset mid-frame:** the frame in flight is aborted and buffered words are discarded. `tx_o` is 1 from the edge that samples `rst_i`.
- `ready_o = !full && !rst_i`, combinational from the FIFO count.
- **Serializer FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: `tx_o` = 1. If the FIFO is non-empty, pop the head word and latch `parity_i`, `two_stop_i` and the effective divisor D. Go to START.
  - START: `tx_o` = 0 for D cycles.
  - DATA: `DataBits` bits, each held D cycles, LSB first.
  - PARITY: entered only if the latched mode is 1 or 2, for one bit of D cycles. Even mode sends the XOR of the data bits; odd mode sends its inverse.
  - STOP: `tx_o` = 1 for D cycles, or 2·D cycles if two stop bits are latched.
  - At the final edge of STOP: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Config sampling:** config is sampled only at pop. Changing the config inputs mid-frame has no effect on the current frame.
- **Counters:**
  - The bit counter reloads to D−1 on every bit entry and decrements to 0.
  - The bit index counts 0..DataBits−1.
  - Use no division; D is used directly.
- **Simultaneous push and pop on a full FIFO:** `ready_o` stays low. The push is not accepted even though a pop occurs that cycle.
- **Simultaneous push and pop on an empty FIFO:** not possible. A pop requires a non-empty FIFO at the edge.

## Timing
- **Latency:** a transfer at edge E0 into an empty FIFO with the serializer idle pops at E1. `tx_o` is low from E1 (registered output).
- **Frame length:** D·(1 + DataBits + P + S) cycles, where P ∈ {0,1} and S ∈ {1,2}.
- **Back-to-back frames:** the next start bit begins at the same edge the previous stop bit ends.
- **`busy_o`:** registered. High from the edge after a transfer until the edge that returns the FSM to IDLE with the FIFO empty.
- `tx_o` is driven from a flop, so it is glitch-free.

## Structure
- **Package `uart_pkg`:** `parity_e` enum (`PARITY_NONE`, `PARITY_EVEN`, `PARITY_ODD`) and `tx_state_e` enum (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`).
- **Sub-module `sync_fifo`:**
  - Parameters Width and Depth; ports push/pop, full/empty.
  - Pointers one bit wider than log2(Depth) for full/empty detection, wrap-around by natural overflow.
  - First-word data on the read port without a read-latency cycle.
- **Top:** FSM, bit counter, shift register, parity accumulator.

## Test plan
- **Basic frame:** DataBits=8, D=4, parity none, 1 stop; send 0x55 → `tx_o` low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, high 4; total 40 cycles; `busy_o` falls at cycle 41.
- **Parity:** D=2; send 0x03 with even parity → parity bit 0; odd parity → 1; 0x07 even → 1; frame 22 cycles.
- **Two stop bits and back-to-back:** D=3, two stop bits; push 0xA0 then 0x0F → stop high exactly 6 cycles, second start bit immediately after, no idle gap.
- **FIFO full:** FifoDepth=4, D=10, push 6 words on consecutive cycles with `valid_i` held → 5 accepted (the first is popped at E1); `ready_o` low from the 6th; the remaining word is accepted when the first frame ends; all 6 words appear in order.
- **Reset mid-frame:** assert `rst_i` for 1 cycle during DATA with 2 words queued → `tx_o` = 1 and `busy_o` = 0 from the next edge; no further frames; `ready_o` = 0 during reset, then 1.
- **Divisor edge:** `divisor_i` = 0 → behaves as D=1, 10-cycle frame for 8N1; changing `divisor_i` mid-frame does not alter the current frame's bit widths.
